// File: rtl/spi_flash_reader.sv
// Runs a serial-flash READ (opcode, 24-bit address, len dummy bytes) through the spi byte engine as one cs burst.
// Data bytes stream out on data_valid with no backpressure and the 4 header echo bytes are dropped; done follows the last capture by 2 cycles.
module spi_flash_reader #(
  parameter int         LEN_W      = 16,
  parameter logic [7:0] CMD_READ   = 8'h03,
  parameter logic [7:0] DUMMY_BYTE = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic             spi_cmd_write,
  output logic [7:0]       spi_bus_in,
  input  logic             spi_busy_write,
  output logic             spi_cmd_read,
  input  logic [7:0]       spi_bus_out,
  input  logic             spi_data_avail
);
  localparam int CW = LEN_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t        state_q, state_d;
  logic [23:0]   addr_q, addr_d;
  logic [CW-1:0] total_q, total_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic          ab_q, ab_d;
  logic          pend_q, pend_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;
  logic          cmd_write_q, cmd_write_d;
  logic [7:0]    bus_in_q, bus_in_d;
  logic          cmd_read_q, cmd_read_d;
  logic [7:0]    tx_byte;
  logic [CW-1:0] rx_next;

  always_comb begin
    if (tx_cnt_q == CW'(0))      tx_byte = CMD_READ;
    else if (tx_cnt_q == CW'(1)) tx_byte = addr_q[23:16];
    else if (tx_cnt_q == CW'(2)) tx_byte = addr_q[15:8];
    else if (tx_cnt_q == CW'(3)) tx_byte = addr_q[7:0];
    else                         tx_byte = DUMMY_BYTE;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    total_d      = total_q;
    tx_cnt_d     = tx_cnt_q;
    rx_cnt_d     = rx_cnt_q;
    ab_d         = ab_q;
    pend_d       = 1'b0;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    cmd_write_d  = 1'b0;
    bus_in_d     = bus_in_q;
    cmd_read_d   = 1'b0;
    rx_next      = rx_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = addr;
          total_d  = CW'(len) + CW'(4);
          tx_cnt_d = '0;
          rx_cnt_d = '0;
          ab_d     = 1'b0;
          state_d  = (len != '0) ? RUN : FIN;
        end
      end
      RUN, DRAIN: begin
        // The idle cycle after each write gives busy_write time to reflect it.
        if (state_q == RUN && !abort && tx_cnt_q < total_q &&
            !spi_busy_write && !cmd_write_q) begin
          cmd_write_d = 1'b1;
          bus_in_d    = tx_byte;
          tx_cnt_d    = tx_cnt_q + CW'(1);
        end
        // pend_q marks the cycle after a read strobe, when bus_out is valid.
        if (pend_q) begin
          rx_next  = rx_cnt_q + CW'(1);
          rx_cnt_d = rx_next;
          if (state_q == RUN && rx_cnt_q >= CW'(4)) begin
            data_valid_d = 1'b1;
            data_out_d   = spi_bus_out;
          end
        end else if (spi_data_avail && !cmd_read_q) begin
          cmd_read_d = 1'b1;
          pend_d     = 1'b1;
        end
        if (state_q == RUN) begin
          if (pend_q && rx_next == total_q) begin
            state_d = FIN;
            ab_d    = 1'b0;
          end else if (abort) begin
            state_d = DRAIN;
            ab_d    = 1'b1;
          end
        end else if (rx_next == tx_cnt_q) begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_d    = 1'b1;
        aborted_d = ab_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      total_q      <= '0;
      tx_cnt_q     <= '0;
      rx_cnt_q     <= '0;
      ab_q         <= 1'b0;
      pend_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      cmd_write_q  <= 1'b0;
      bus_in_q     <= '0;
      cmd_read_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      total_q      <= total_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
      ab_q         <= ab_d;
      pend_q       <= pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      cmd_write_q  <= cmd_write_d;
      bus_in_q     <= bus_in_d;
      cmd_read_q   <= cmd_read_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign spi_cmd_write = cmd_write_q;
  assign spi_bus_in    = bus_in_q;
  assign spi_cmd_read  = cmd_read_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural spi byte engine plus flash responder, table of read transfers,
// and hand-written sequences for len=0, abort, ignored start and mid-transfer reset.
module tb_spi_flash_reader;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [23:0]      addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, aborted, data_valid;
  logic [7:0]       data_out;
  logic             spi_cmd_write, spi_busy_write, spi_cmd_read, spi_data_avail;
  logic [7:0]       spi_bus_in, spi_bus_out;

  spi_flash_reader #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .len(len), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .data_out(data_out), .data_valid(data_valid),
    .spi_cmd_write(spi_cmd_write), .spi_bus_in(spi_bus_in), .spi_busy_write(spi_busy_write),
    .spi_cmd_read(spi_cmd_read), .spi_bus_out(spi_bus_out), .spi_data_avail(spi_data_avail)
  );

  always #5 clk = ~clk;

  // Engine model: one-byte tx buffer, 16 clk per byte, cs_n low while bytes are back to back.
  logic       e_full, e_shift, e_avail, cs_n;
  logic [7:0] e_buf, e_rx;
  logic [3:0] e_cnt;
  int         e_idx;
  logic [7:0] fdata [0:15];
  logic [7:0] mosi_q [$];

  function automatic logic [7:0] flash_byte(input int i);
    return (i < 4) ? 8'hEE : fdata[(i - 4) % 16];
  endfunction

  assign spi_busy_write = e_full;
  assign spi_data_avail = e_avail;
  assign spi_bus_out    = e_rx;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_full <= 1'b0; e_shift <= 1'b0; e_avail <= 1'b0; cs_n <= 1'b1;
      e_buf <= '0; e_rx <= '0; e_cnt <= '0; e_idx <= 0;
    end else begin
      if (spi_cmd_read) e_avail <= 1'b0;
      if (!e_shift) begin
        if (e_full) begin
          e_shift <= 1'b1; e_cnt <= '0; cs_n <= 1'b0; e_full <= 1'b0; e_idx <= 0;
          mosi_q.push_back(e_buf);
        end else if (spi_cmd_write) begin
          e_buf <= spi_bus_in; e_full <= 1'b1;
        end
      end else begin
        e_cnt <= e_cnt + 4'd1;
        if (e_cnt == 4'd15) begin
          e_rx <= flash_byte(e_idx); e_idx <= e_idx + 1; e_avail <= 1'b1;
          if (e_full) begin
            e_full <= 1'b0; mosi_q.push_back(e_buf);
          end else if (spi_cmd_write) begin
            mosi_q.push_back(spi_bus_in);
          end else begin
            e_shift <= 1'b0; cs_n <= 1'b1;
          end
        end else if (spi_cmd_write) begin
          e_buf <= spi_bus_in; e_full <= 1'b1;
        end
      end
    end
  end

  int         total = 0, bad = 0;
  int         wr_cnt, rd_cnt, done_cnt, cs_low, cs_rise, proto_bad = 0;
  logic       last_ab;
  logic       prev_wr = 1'b0, prev_rd = 1'b0, prev_cs = 1'b1;
  logic [7:0] dv_q [$];

  always @(negedge clk) begin
    if (!reset) begin
      if (spi_cmd_write) wr_cnt++;
      if (spi_cmd_read) rd_cnt++;
      if (spi_cmd_write && (spi_busy_write || prev_wr)) proto_bad++;
      if (spi_cmd_read && prev_rd) proto_bad++;
      if (data_valid) dv_q.push_back(data_out);
      if (done) begin done_cnt++; last_ab = aborted; end
      if (cs_n === 1'b0) cs_low++;
      if (cs_n === 1'b1 && prev_cs === 1'b0) cs_rise++;
    end
    prev_wr = spi_cmd_write; prev_rd = spi_cmd_read; prev_cs = cs_n;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clear_obs();
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; cs_low = 0; cs_rise = 0; last_ab = 1'b0;
    dv_q.delete(); mosi_q.delete();
  endtask

  task automatic start_xfer(input logic [23:0] a, input logic [LEN_W-1:0] l);
    addr = a; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      @(posedge clk); #1;
    end
    chk({nm, "_done_cnt"}, done_cnt, 1);
  endtask

  task automatic wait_mosi(input int n);
    for (int i = 0; i < 2000 && mosi_q.size() < n; i++) begin
      @(posedge clk); #1;
    end
    chk("mosi_progress", mosi_q.size() >= n, 1);
  endtask

  typedef struct {
    logic [23:0] a;
    logic [15:0] l;
    logic [31:0] d;    // data bytes, first byte in [31:24]
    logic [31:0] hdr;  // expected opcode + address bytes
    int          cs_cyc;
  } vec_t;

  task automatic load_flash(input logic [31:0] d);
    for (int k = 0; k < 16; k++) fdata[k] = 8'h00;
    for (int k = 0; k < 4; k++) fdata[k] = d[31-8*k -: 8];
  endtask

  task automatic check_xfer(input string nm, input vec_t v);
    int nz;
    logic [31:0] hdr;
    wait_done(nm);
    chk({nm, "_aborted"}, last_ab, 0);
    chk({nm, "_busy_after"}, busy, 0);
    chk({nm, "_writes"}, wr_cnt, 4 + v.l);
    chk({nm, "_reads"}, rd_cnt, 4 + v.l);
    hdr = {mosi_q[0], mosi_q[1], mosi_q[2], mosi_q[3]};
    chk({nm, "_mosi_hdr"}, hdr, v.hdr);
    nz = 0;
    for (int k = 4; k < mosi_q.size(); k++) if (mosi_q[k] != 8'h00) nz++;
    chk({nm, "_mosi_dummy_nonzero"}, nz, 0);
    chk({nm, "_dv_count"}, dv_q.size(), v.l);
    for (int k = 0; k < v.l && k < 4; k++) chk({nm, "_data"}, dv_q[k], v.d[31-8*k -: 8]);
    chk({nm, "_cs_low_cycles"}, cs_low, v.cs_cyc);
    chk({nm, "_cs_rises"}, cs_rise, 1);
  endtask

  vec_t rows [4];
  int   wr0;
  logic [31:0] hdr;

  initial begin
    rows[0] = '{24'h123456, 16'd3, 32'hA1B2C300, 32'h03123456, 112};
    rows[1] = '{24'hABCDEF, 16'd1, 32'h7E000000, 32'h03ABCDEF, 80};
    rows[2] = '{24'h000000, 16'd4, 32'h01020304, 32'h03000000, 128};
    rows[3] = '{24'hFFFFFF, 16'd2, 32'h00FF0000, 32'h03FFFFFF, 96};
    clear_obs();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl_outs", {busy, done, aborted, data_valid, spi_cmd_write, spi_cmd_read}, 0);
    chk("rst_data_outs", {data_out, spi_bus_in}, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    for (int r = 0; r < 4; r++) begin
      clear_obs();
      load_flash(rows[r].d);
      start_xfer(rows[r].a, rows[r].l[LEN_W-1:0]);
      check_xfer($sformatf("row%0d", r), rows[r]);
      repeat (3) @(posedge clk);
      #1;
    end

    // len=0: done two cycles after start, no spi activity.
    clear_obs();
    start_xfer(24'h777777, '0);
    chk("len0_c1_done", done, 0);
    chk("len0_c1_busy", busy, 1);
    @(posedge clk); #1;
    chk("len0_c2_done", done, 1);
    chk("len0_c2_aborted", aborted, 0);
    chk("len0_c2_busy", busy, 1);
    @(posedge clk); #1;
    chk("len0_c3_done_busy", {done, busy}, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("len0_spi_strobes", wr_cnt + rd_cnt, 0);
    chk("len0_cs_low", cs_low, 0);

    // Abort after the 6th MOSI byte has entered the shifter.
    clear_obs();
    load_flash(32'h11223344);
    start_xfer(24'h00ABCD, 16'd16);
    wait_mosi(6);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wr0 = wr_cnt;
    wait_done("abort");
    chk("abort_no_wr_after", wr_cnt, wr0);
    chk("abort_writes", wr_cnt, 6);
    chk("abort_aborted", last_ab, 1);
    chk("abort_dv_count", dv_q.size(), 0);
    chk("abort_rx_eq_tx", rd_cnt, wr_cnt);
    chk("abort_cs_idle", cs_n, 1);
    chk("abort_busy_after", busy, 0);

    // Second start and address churn while busy are ignored.
    clear_obs();
    load_flash(32'hC0FFEE00);
    start_xfer(24'h111111, 16'd3);
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      addr  = 24'($urandom);
      start = (i == 20);
      len   = 16'd5;
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_done("restart");
    hdr = {mosi_q[0], mosi_q[1], mosi_q[2], mosi_q[3]};
    chk("restart_hdr", hdr, 32'h03111111);
    chk("restart_dv_count", dv_q.size(), 3);
    chk("restart_data2", dv_q[2], 8'hEE);
    repeat (50) @(posedge clk);
    #1;
    chk("restart_writes", wr_cnt, 7);
    chk("restart_single_done", done_cnt, 1);
    chk("restart_busy", busy, 0);

    // Asynchronous reset in the middle of a data byte.
    clear_obs();
    load_flash(32'h99887766);
    start_xfer(24'h0A0B0C, 16'd8);
    wait_mosi(6);
    repeat (5) @(posedge clk);
    #1;
    chk("prerst_busy", busy, 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midrst_ctrl_outs", {busy, done, aborted, data_valid, spi_cmd_write, spi_cmd_read}, 0);
    chk("midrst_data_outs", {data_out, spi_bus_in}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt, 0);
    clear_obs();
    load_flash(32'h5A6B0000);
    start_xfer(24'h345678, 16'd2);
    check_xfer("postrst", '{24'h345678, 16'd2, 32'h5A6B0000, 32'h03345678, 96});

    chk("protocol_violations", proto_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- Sequencer for the spi byte engine: runs a complete serial-flash READ (cmd 0x03 + 24-bit address + N data bytes) as one chip-select burst.
- Keeps the engine's one-byte transmit buffer topped up so cs_n never deasserts mid-transaction.
- Drains received bytes and streams only the data bytes to the consumer. Sits between the boot/loader logic and the spi instance, and is the only driver of the engine's cmd_write and cmd_read.

Parameters:
- LEN_W, 16, width of the byte-count input; max transfer is 2^LEN_W-1 bytes.
- CMD_READ, 8'h03, opcode sent as the first byte.
- DUMMY_BYTE, 8'h00, byte shifted out while data is clocked in.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- addr  in  24  flash byte address; latched on accepted start.
- len  in  LEN_W  data byte count; latched on accepted start.
- abort  in  1  stop issuing bytes, drain in-flight bytes, then finish.
- busy  out  1  high from accepted start until the done pulse, inclusive.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  valid with done; 1 if the transfer ended through abort.
- data_out  out  8  received data byte.
- data_valid  out  1  one-cycle strobe qualifying data_out. There is no backpressure; the consumer must accept.
- spi_cmd_write  out  1  write-strobe to engine cmd_write.
- spi_bus_in  out  8  byte to engine bus_in.
- spi_busy_write  in  1  engine tx buffer full.
- spi_cmd_read  out  1  read-strobe to engine cmd_read.
- spi_bus_out  in  8  engine bus_out; valid the cycle after spi_cmd_read.
- spi_data_avail  in  1  engine has a received byte.

Behaviour:
- Reset (async):
  - State = IDLE; all outputs 0; counters 0.
  - A reset mid-transfer abandons it with no done pulse. The engine shares the reset and returns to its own idle.
- Latched values:
  - total = len+4, held in LEN_W+1 bits.
  - tx byte sequence: CMD_READ, addr[23:16], addr[15:8], addr[7:0], then len × DUMMY_BYTE.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - start=1 and len≠0: latch addr/len, clear tx_cnt/rx_cnt, go to RUN; busy rises the next cycle.
  - start=1 and len=0: go to FIN, with no spi strobes.
  - start outside IDLE is ignored.
- RUN, tx side:
  - Pulse spi_cmd_write for one cycle, with spi_bus_in = byte[tx_cnt], when all of these hold: tx_cnt<total; spi_busy_write=0; spi_cmd_write was 0 in the previous cycle. The gap cycle lets busy_write reflect the previous write.
  - Increment tx_cnt on each pulse.
  - spi_bus_in holds its value outside pulses.
- RUN/DRAIN, rx side:
  - When spi_data_avail=1 and no read is pending, pulse spi_cmd_read for one cycle and set pending.
  - On the next cycle, capture spi_bus_out, clear pending, and increment rx_cnt.
  - If the pre-increment rx_cnt ≥ 4 and the state is RUN, assert data_valid with data_out = the captured byte in that same cycle.
  - Bytes 0..3 (the header echo) are discarded.
  - spi_cmd_read is never asserted on two consecutive cycles.
- RUN → FIN: when rx_cnt reaches total. aborted=0.
- RUN → DRAIN: when abort=1. From that cycle no further spi_cmd_write is issued.
- DRAIN:
  - Keep reading bytes with data_valid suppressed.
  - Go to FIN when rx_cnt = tx_cnt. aborted=1.
  - abort in IDLE or FIN is ignored.
- FIN: assert done=1 for one cycle, drive aborted, then go to IDLE. busy stays 1 during FIN and drops the next cycle.
- Simultaneous events:
  - A write pulse and a read pulse in the same cycle are legal.
  - abort in the same cycle as the final rx capture: the completion wins, aborted=0.
- Throughput: a byte lasts 16 clk cycles, so read servicing (2 cycles) cannot overrun.
- Expected engine behaviour: cs_n stays low continuously from the first write to the final byte.

Test Plan:
- addr=0x123456, len=3, flash model returns 0xA1,0xB2,0xC3 → MOSI bytes 03 12 34 56 00 00 00; data_valid ×3 with A1,B2,C3; cs_n low for exactly 7×16 cycles; done=1, aborted=0.
- len=0, start → done pulse 2 cycles after start, aborted=0; spi_cmd_write/spi_cmd_read never asserted; cs_n stays 1.
- len=16 with abort asserted after the 6th MOSI byte → no writes after abort; remaining in-flight bytes are read but data_valid stays 0; done with aborted=1; rx_cnt = tx_cnt.
- start pulsed again while busy, plus random addr changes mid-transfer → ignored; MOSI header reflects the originally latched addr.
- Async reset asserted mid-data-byte (len=8) → all outputs 0 immediately with no clock edge; no done pulse; a subsequent start with len=2 completes correctly.
- Protocol checker throughout → spi_cmd_write never asserted while spi_busy_write=1 or on consecutive cycles; spi_cmd_read never on consecutive cycles.
